// File: rtl/prefix_adder_pkg.sv
// Shared types and sizing helpers for the
// pipelined Kogge-Stone adder/subtractor.
package prefix_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int levels(input int w);
    return $clog2(w);
  endfunction

  function automatic int nstg(input int w, input int pe);
    return 1 + (levels(w) + pe - 1) / pe;
  endfunction

endpackage

// File: rtl/pipelined_prefix_adder_cell.sv
// Kogge-Stone black cell: merges a high
// (g,p) span with the adjacent low span.
module prefix_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  // generate/propagate combine
  assign g = gh | (ph & gl);
  assign p = ph & pl;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined parallel-prefix add/sub with
// valid/ready flow control and bubble collapse.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PIPE_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LEVELS = levels(WIDTH);
  localparam int NSTG   = nstg(WIDTH, PIPE_EVERY);
  localparam int LST    = NSTG - 1;

  // Node j holds the span ending at bit j-1;
  // node 0 is the carry-in at position -1.
  logic [WIDTH-1:0] a_q [NSTG];
  logic [WIDTH-1:0] b_q [NSTG];
  logic [WIDTH-1:0] g_q [NSTG];
  logic [WIDTH-1:0] p_q [NSTG];
  logic [NSTG-1:0]  v_q;

  logic [WIDTH-1:0] a_d [NSTG];
  logic [WIDTH-1:0] b_d [NSTG];
  logic [WIDTH-1:0] g_d [NSTG];
  logic [WIDTH-1:0] p_d [NSTG];
  logic [NSTG-1:0]  v_d;
  logic [NSTG:0]    adv;

  logic [WIDTH-1:0] lin_g  [LEVELS];
  logic [WIDTH-1:0] lin_p  [LEVELS];
  logic [WIDTH-1:0] lout_g [LEVELS];
  logic [WIDTH-1:0] lout_p [LEVELS];

  op_e              op;
  logic [WIDTH-1:0] bx;
  logic             c0;
  logic [WIDTH-1:0] cy;

  assign op = op_e'(in_op);
  assign bx = (op == OP_SUB) ? ~in_b : in_b;
  assign c0 = (op == OP_SUB) ? 1'b1 : in_cin;

  assign v_d[0] = in_valid;
  assign a_d[0] = in_a;
  assign b_d[0] = bx;
  assign g_d[0] = {in_a[WIDTH-2:0] & bx[WIDTH-2:0], c0};
  assign p_d[0] = {in_a[WIDTH-2:0] | bx[WIDTH-2:0], 1'b0};

  // stall chain: a stage moves if empty or
  // if the next one moves
  assign adv[NSTG] = out_ready;
  for (genvar k = 0; k < NSTG; k++) begin : g_adv
    assign adv[k] = !v_q[k] || adv[k+1];
  end
  assign in_ready = adv[0];

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int S = l / PIPE_EVERY + 1;
    localparam int D = 1 << l;
    if (l % PIPE_EVERY == 0) begin : g_src_reg
      assign lin_g[l] = g_q[S-1];
      assign lin_p[l] = p_q[S-1];
    end else begin : g_src_lvl
      assign lin_g[l] = lout_g[l-1];
      assign lin_p[l] = lout_p[l-1];
    end
    for (genvar j = 0; j < WIDTH; j++) begin : g_bit
      if (j >= D) begin : g_cell
        prefix_cell u_cell (
          .gh (lin_g[l][j]),
          .ph (lin_p[l][j]),
          .gl (lin_g[l][j-D]),
          .pl (lin_p[l][j-D]),
          .g  (lout_g[l][j]),
          .p  (lout_p[l][j])
        );
      end else begin : g_pass
        assign lout_g[l][j] = lin_g[l][j];
        assign lout_p[l][j] = lin_p[l][j];
      end
    end
  end

  for (genvar k = 1; k < NSTG; k++) begin : g_stg
    localparam int LAST =
      ((k * PIPE_EVERY < LEVELS) ?
       k * PIPE_EVERY : LEVELS) - 1;
    assign v_d[k] = v_q[k-1];
    assign a_d[k] = a_q[k-1];
    assign b_d[k] = b_q[k-1];
    assign g_d[k] = lout_g[LAST];
    assign p_d[k] = lout_p[LAST];
  end

  // pipeline registers; each stage loads
  // only when it is allowed to advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < NSTG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        g_q[k] <= '0;
        p_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_d[k];
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          g_q[k] <= g_d[k];
          p_q[k] <= p_d[k];
        end
      end
    end
  end

  // final node j is the carry into bit j;
  // the MSB cell is folded in here
  assign cy        = g_q[LST];
  assign out_valid = v_q[LST];
  assign out_sum   = a_q[LST] ^ b_q[LST] ^ cy;
  assign out_cout  =
    (a_q[LST][WIDTH-1] & b_q[LST][WIDTH-1]) |
    ((a_q[LST][WIDTH-1] | b_q[LST][WIDTH-1]) &
     cy[WIDTH-1]);
  assign out_ovf   = cy[WIDTH-1] ^ out_cout;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed and scoreboarded bench for the
// pipelined prefix adder at two parameter sets.
module tb_pipelined_prefix_adder;

  localparam int W  = 32;
  localparam int W2 = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          iv, ir, ov, ordy;
  logic [W-1:0]  a, b, sum;
  logic          cin, op, cout, ovf;

  logic          iv2, ir2, ov2, ordy2;
  logic [W2-1:0] a2, b2, sum2;
  logic          cin2, op2, cout2, ovf2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nout1, first1, last1;
  int lat;
  logic [W-1:0]  held;
  logic [65:0]   e;
  logic [65:0]   q1 [$];
  logic [65:0]   q2 [$];

  always #5 clk = ~clk;

  pipelined_prefix_adder #(
    .WIDTH(W), .PIPE_EVERY(2)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir),
    .in_a(a), .in_b(b),
    .in_cin(cin), .in_op(op),
    .out_valid(ov), .out_ready(ordy),
    .out_sum(sum), .out_cout(cout),
    .out_ovf(ovf)
  );

  pipelined_prefix_adder #(
    .WIDTH(W2), .PIPE_EVERY(1)
  ) u_dut13 (
    .clk(clk), .rst(rst),
    .in_valid(iv2), .in_ready(ir2),
    .in_a(a2), .in_b(b2),
    .in_cin(cin2), .in_op(op2),
    .out_valid(ov2), .out_ready(ordy2),
    .out_sum(sum2), .out_cout(cout2),
    .out_ovf(ovf2)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // reference: {ovf, cout, sum}, ovf by sign rule
  function automatic logic [65:0] model(
    input logic [63:0] x, y,
    input logic c, o, input int w);
    logic [63:0] m, yy, full, s;
    logic cc, co, vv;
    m    = (64'd1 << w) - 64'd1;
    yy   = o ? (~y & m) : (y & m);
    cc   = o ? 1'b1 : c;
    full = (x & m) + yy + {63'd0, cc};
    s    = full & m;
    co   = full[w];
    if (o)
      vv = (x[w-1] != y[w-1]) && (s[w-1] != x[w-1]);
    else
      vv = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    return {vv, co, s};
  endfunction

  // sample handshakes just after the negedge,
  // then advance one cycle
  task automatic tick();
    #1;
    if (iv && ir)
      q1.push_back(model(64'(a), 64'(b), cin, op, W));
    if (iv2 && ir2)
      q2.push_back(model(64'(a2), 64'(b2), cin2, op2, W2));
    if (ov && ordy) begin
      nout1++;
      if (nout1 == 1) first1 = cyc;
      last1 = cyc;
      if (q1.size() == 0) check("sb32_extra", 1, 0);
      else begin
        e = q1.pop_front();
        check("sb32_res", 64'({ovf, cout, sum}),
              64'({e[65], e[64], e[W-1:0]}));
      end
    end
    if (ov2 && ordy2) begin
      if (q2.size() == 0) check("sb13_extra", 1, 0);
      else begin
        e = q2.pop_front();
        check("sb13_res", 64'({ovf2, cout2, sum2}),
              64'({e[65], e[64], e[W2-1:0]}));
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_one(input string tag,
                         input logic [W-1:0] x, y,
                         input logic c, o,
                         input logic [W-1:0] es,
                         input logic ec, ev);
    iv = 1'b1; a = x; b = y; cin = c; op = o;
    tick();
    iv = 1'b0;
    lat = 1;
    while (!ov && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf), 64'(ev));
    tick();
  endtask

  function automatic logic [W-1:0] pick32();
    case ($urandom % 4)
      0:       return '1;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [W2-1:0] pick13();
    case ($urandom % 4)
      0:       return '1;
      1:       return 13'h1000;
      default: return W2'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    iv = 0; a = 0; b = 0; cin = 0; op = 0; ordy = 1;
    iv2 = 0; a2 = 0; b2 = 0; cin2 = 0; op2 = 0; ordy2 = 1;
    nout1 = 0; first1 = 0; last1 = 0;

    repeat (2) @(negedge clk);
    check("rst_valid", 64'(ov), 0);
    check("rst_sum", 64'(sum), 0);
    check("rst_cout", 64'(cout), 0);
    check("rst_ovf", 64'(ovf), 0);
    rst = 1'b0;
    #1 check("rst_in_ready", 64'(ir), 1);
    @(negedge clk);

    run_one("add_ripple", 32'hFFFF_FFFF, 32'h0, 1, 0,
            32'h0, 1, 0);
    run_one("sub_minneg", 32'h8000_0000, 32'h1, 0, 1,
            32'h7FFF_FFFF, 1, 1);
    run_one("sub_5_7", 32'd5, 32'd7, 0, 1,
            32'hFFFF_FFFE, 0, 0);
    run_one("add_posovf", 32'h7FFF_FFFF, 32'h1, 0, 0,
            32'h8000_0000, 0, 1);
    run_one("add_plain", 32'h1234_5678, 32'h1111_1111, 0, 0,
            32'h2345_6789, 0, 0);
    run_one("sub_cin_ign", 32'd10, 32'd3, 1, 1,
            32'd7, 1, 0);
    run_one("add_negovf", 32'h8000_0000, 32'h8000_0000, 0, 0,
            32'h0, 1, 1);
    run_one("add_cin_only", 32'h0, 32'h0, 1, 0,
            32'h1, 0, 0);

    nout1 = 0;
    for (int i = 0; i < 8; i++) begin
      iv = 1; op = 0; cin = i[0];
      a = 32'h1111_1111 * i; b = ~a + 32'(i);
      #1 check("b2b_in_ready", 64'(ir), 1);
      tick();
    end
    iv = 0;
    repeat (10) tick();
    check("b2b_count", 64'(nout1), 8);
    check("b2b_span", 64'(last1 - first1), 7);

    ordy = 0; nout1 = 0;
    for (int i = 0; i < 6; i++) begin
      iv = 1; a = pick32(); b = pick32();
      op = i[0]; cin = i[1];
      #1 check("stall_in_ready", 64'(ir), 64'(i < 4));
      tick();
    end
    iv = 0;
    held = sum;
    repeat (5) begin
      tick();
      check("stall_hold_sum", 64'(sum), 64'(held));
      check("stall_hold_valid", 64'(ov), 1);
    end
    ordy = 1;
    repeat (10) tick();
    check("stall_count", 64'(nout1), 4);
    check("stall_drained", 64'(q1.size()), 0);

    ordy = 0;
    for (int i = 0; i < 3; i++) begin
      iv = 1; a = pick32(); b = pick32(); op = 0;
      tick();
    end
    iv = 0;
    tick();
    check("arst_full", 64'(ov), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 64'(ov), 0);
    check("arst_sum", 64'(sum), 0);
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    ordy = 1; nout1 = 0;
    repeat (10) tick();
    check("arst_no_ghost", 64'(nout1), 0);

    for (int i = 0; i < 400; i++) begin
      iv   = ($urandom % 4) != 0;
      a    = pick32(); b = pick32();
      cin  = $urandom % 2; op = $urandom % 2;
      ordy = ($urandom % 3) != 0;
      iv2  = ($urandom % 4) != 0;
      a2   = pick13(); b2 = pick13();
      cin2 = $urandom % 2; op2 = $urandom % 2;
      ordy2 = ($urandom % 3) != 0;
      tick();
    end
    iv = 0; iv2 = 0; ordy = 1; ordy2 = 1;
    repeat (20) tick();
    check("rand32_drained", 64'(q1.size()), 0);
    check("rand13_drained", 64'(q2.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
